// File: rtl/pcim_burst_splitter_pkg.sv
// AOSF1Types: shared SoftReg and PCIM command types
// used by the PCIM read/write stages and the burst splitter.
package AOSF1Types;

    localparam logic [31:0] PCIM_SPLITTER_CSR = 32'h10;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [63:0] data;
    } SoftRegReq;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } SoftRegResp;

    typedef struct packed {
        logic [39:0] addr;
        logic [7:0]  len;
        logic [15:0] id;
    } PCIM_Command;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        STALL
    } splitter_state_e;

endpackage

// File: rtl/pcim_burst_splitter.sv
// Splits a SoftReg-programmed line transfer into PCIM bursts
// that never cross a MAX_BEATS boundary, with credit throttling.
module pcim_burst_splitter
    import AOSF1Types::*;
#(
    parameter int unsigned MAX_BEATS       = 64,
    parameter int unsigned MAX_OUTSTANDING = 32,
    parameter logic [31:0] CSR_ADDR        = PCIM_SPLITTER_CSR
) (
    input  logic        clk,
    input  logic        rst,
    input  SoftRegReq   softreg_req,
    output SoftRegResp  softreg_resp,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output PCIM_Command cmd,
    input  logic        cpl_valid
);

    localparam logic [39:0] MB      = 40'(MAX_BEATS);
    localparam logic [5:0]  MAX_OUT = 6'(MAX_OUTSTANDING);

    splitter_state_e state_q, state_d;
    PCIM_Command     cmd_q, cmd_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic [39:0]     addr_q, addr_d;
    logic [23:0]     rem_q, rem_d;
    logic [5:0]      out_q, out_d;
    logic [4:0]      id_q, id_d;
    logic [15:0]     bursts_q, bursts_d;
    logic            ovl_q, ovl_d;
    logic            unf_q, unf_d;

    logic            csr_hit, csr_wr, csr_rd, accept;
    logic [23:0]     acc_beats;
    logic [39:0]     addr_n;
    logic [23:0]     rem_n;

    function automatic logic [23:0] burst_beats(
        input logic [39:0] a,
        input logic [23:0] r
    );
        logic [39:0] room;
        room = MB - (a & (MB - 40'd1));
        if ({16'b0, r} < room) return r;
        return room[23:0];
    endfunction

    function automatic PCIM_Command make_cmd(
        input logic [39:0] a,
        input logic [23:0] r,
        input logic [4:0]  i
    );
        PCIM_Command c;
        logic [23:0] n;
        n      = burst_beats(a, r) - 24'd1;
        c.addr = a;
        c.len  = n[7:0];
        c.id   = {11'b0, i};
        return c;
    endfunction

    assign csr_hit = softreg_req.valid && (softreg_req.addr == CSR_ADDR);
    assign csr_wr  = csr_hit && softreg_req.is_write;
    assign csr_rd  = csr_hit && !softreg_req.is_write;
    assign accept  = cmd_valid_q && cmd_ready;

    assign acc_beats = {16'b0, cmd_q.len} + 24'd1;
    assign addr_n    = addr_q + {16'b0, acc_beats};
    assign rem_n     = rem_q - acc_beats;

    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;

    // Status read is answered combinationally in the request cycle
    always_comb begin
        softreg_resp.valid = csr_rd && !rst;
        softreg_resp.data  = {
            (state_q != IDLE) || (out_q != 6'd0),
            ovl_q, unf_q, 13'b0, rem_q, bursts_q, 2'b0, out_q
        };
    end

    // Next-state, credit accounting and command generation
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        id_d        = id_q;
        bursts_d    = bursts_q;
        out_d       = out_q;
        ovl_d       = csr_rd ? 1'b0 : ovl_q;
        unf_d       = csr_rd ? 1'b0 : unf_q;

        if (cpl_valid && out_q == 6'd0) unf_d = 1'b1;
        if (accept && !cpl_valid) out_d = out_q + 6'd1;
        else if (!accept && cpl_valid && out_q != 6'd0)
            out_d = out_q - 6'd1;

        if (csr_wr && state_q != IDLE) ovl_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (csr_wr && softreg_req.data[23:0] != 24'd0) begin
                    addr_d = softreg_req.data[63:24];
                    rem_d  = softreg_req.data[23:0];
                    if (out_q < MAX_OUT) begin
                        cmd_d = make_cmd(softreg_req.data[63:24],
                                         softreg_req.data[23:0], id_q);
                        cmd_valid_d = 1'b1;
                        state_d     = ISSUE;
                    end else begin
                        state_d = STALL;
                    end
                end
            end
            ISSUE: begin
                if (accept) begin
                    addr_d   = addr_n;
                    rem_d    = rem_n;
                    id_d     = id_q + 5'd1;
                    bursts_d = bursts_q + 16'd1;
                    if (rem_n == 24'd0) begin
                        cmd_valid_d = 1'b0;
                        state_d     = IDLE;
                    end else if (out_d < MAX_OUT) begin
                        cmd_d = make_cmd(addr_n, rem_n, id_d);
                    end else begin
                        cmd_valid_d = 1'b0;
                        state_d     = STALL;
                    end
                end
            end
            STALL: begin
                if (out_q < MAX_OUT) begin
                    cmd_d       = make_cmd(addr_q, rem_q, id_q);
                    cmd_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            default: begin
                cmd_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            addr_q      <= '0;
            rem_q       <= '0;
            out_q       <= '0;
            id_q        <= '0;
            bursts_q    <= '0;
            ovl_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            out_q       <= out_d;
            id_q        <= id_d;
            bursts_q    <= bursts_d;
            ovl_q       <= ovl_d;
            unf_q       <= unf_d;
        end
    end

endmodule

// File: tb/tb_pcim_burst_splitter.sv
// Bench for pcim_burst_splitter: scoreboarded command stream
// plus status-word checks over the main transfer scenarios.
module tb_pcim_burst_splitter;
    import AOSF1Types::*;

    logic        clk;
    logic        rst;
    SoftRegReq   softreg_req;
    SoftRegResp  softreg_resp;
    logic        cmd_valid;
    logic        cmd_ready;
    PCIM_Command cmd;
    logic        cpl_valid;

    int tests;
    int fails;
    int accepted;
    PCIM_Command exp_q[$];

    pcim_burst_splitter dut (
        .clk          (clk),
        .rst          (rst),
        .softreg_req  (softreg_req),
        .softreg_resp (softreg_resp),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd          (cmd),
        .cpl_valid    (cpl_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every accepted command must match the next expected one
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            PCIM_Command e;
            accepted++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL cmd_unexpected got=%h expected=none", cmd);
            end else begin
                e = exp_q.pop_front();
                if (cmd !== e) begin
                    fails++;
                    $display("FAIL cmd got=%h expected=%h", cmd, e);
                end
            end
        end
    end

    function automatic logic [63:0] st(
        input logic busy, input logic ov, input logic un,
        input logic [23:0] rem, input logic [15:0] b, input logic [5:0] o
    );
        return {busy, ov, un, 13'b0, rem, b, 2'b0, o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [39:0] a, input logic [7:0] l,
                        input logic [15:0] i);
        PCIM_Command c;
        c.addr = a;
        c.len  = l;
        c.id   = i;
        exp_q.push_back(c);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic csr_write(input logic [39:0] a, input logic [23:0] n);
        softreg_req.valid    = 1'b1;
        softreg_req.is_write = 1'b1;
        softreg_req.addr     = PCIM_SPLITTER_CSR;
        softreg_req.data     = {a, n};
        tick();
        softreg_req = '0;
    endtask

    task automatic csr_read(output logic [63:0] d, output logic v);
        softreg_req.valid    = 1'b1;
        softreg_req.is_write = 1'b0;
        softreg_req.addr     = PCIM_SPLITTER_CSR;
        softreg_req.data     = '0;
        #1;
        v = softreg_resp.valid;
        d = softreg_resp.data;
        tick();
        softreg_req = '0;
    endtask

    task automatic pulse_cpl();
        cpl_valid = 1'b1;
        tick();
        cpl_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain got=%0d expected=0 pending", nm,
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_status(input string nm, input logic [63:0] e);
        logic [63:0] d;
        logic        v;
        csr_read(d, v);
        tests++;
        if (v !== 1'b1 || d !== e) begin
            fails++;
            $display("FAIL %s got=%b/%h expected=1/%h", nm, v, d, e);
        end
    endtask

    task automatic test_reset();
        logic [63:0] d;
        logic        v;
        rst = 1'b1;
        tick();
        tick();
        csr_read(d, v);
        tests++;
        if (v !== 1'b0 || cmd_valid !== 1'b0 || cmd !== '0) begin
            fails++;
            $display("FAIL reset_outputs got=%b/%b/%h expected=0/0/0",
                     v, cmd_valid, cmd);
        end
        rst = 1'b0;
        chk_status("reset_status", 64'h0);
    endtask

    task automatic test_two_bursts();
        do_reset();
        cmd_ready = 1'b1;
        push(40'h0, 8'd63, 16'd0);
        push(40'h40, 8'd63, 16'd1);
        csr_write(40'h0, 24'd128);
        tests++;
        if (cmd_valid !== 1'b1) begin
            fails++;
            $display("FAIL first_cmd_latency got=%b expected=1", cmd_valid);
        end
        wait_drain("two_bursts");
        tick();
        pulse_cpl();
        pulse_cpl();
        chk_status("two_bursts_idle", st(0, 0, 0, 24'd0, 16'd2, 6'd0));
    endtask

    task automatic test_boundary();
        do_reset();
        cmd_ready = 1'b1;
        push(40'h3E, 8'd1, 16'd0);
        push(40'h40, 8'd2, 16'd1);
        csr_write(40'h3E, 24'd5);
        wait_drain("boundary");
        tick();
        chk_status("boundary_status", st(1, 0, 0, 24'd0, 16'd2, 6'd2));
    endtask

    task automatic test_stall();
        int base;
        do_reset();
        cmd_ready = 1'b1;
        base = accepted;
        for (int i = 0; i < 32; i++)
            push(40'(i * 64), 8'd63, 16'(i % 32));
        csr_write(40'h0, 24'd2560);
        for (int i = 0; i < 60; i++) tick();
        tests++;
        if (accepted - base != 32 || cmd_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_count got=%0d/%b expected=32/0",
                     accepted - base, cmd_valid);
        end
        chk_status("stall_status", st(1, 0, 0, 24'd512, 16'd32, 6'd32));
        push(40'h800, 8'd63, 16'd0);
        pulse_cpl();
        for (int i = 0; i < 10; i++) tick();
        tests++;
        if (accepted - base != 33 || cmd_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_credit got=%0d/%b expected=33/0",
                     accepted - base, cmd_valid);
        end
        wait_drain("stall");
    endtask

    task automatic test_backpressure();
        PCIM_Command e;
        int base;
        do_reset();
        cmd_ready = 1'b0;
        e.addr = 40'h100;
        e.len  = 8'd2;
        e.id   = 16'd0;
        base = accepted;
        csr_write(40'h100, 24'd3);
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (cmd_valid !== 1'b1 || cmd !== e) begin
                fails++;
                $display("FAIL hold_cycle%0d got=%b/%h expected=1/%h",
                         i, cmd_valid, cmd, e);
            end
            tick();
        end
        exp_q.push_back(e);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        tests++;
        if (accepted - base != 1 || cmd_valid !== 1'b0) begin
            fails++;
            $display("FAIL release got=%0d/%b expected=1/0",
                     accepted - base, cmd_valid);
        end
    endtask

    task automatic test_overlap();
        do_reset();
        cmd_ready = 1'b0;
        csr_write(40'h0, 24'd64);
        csr_write(40'h1000, 24'd10);
        chk_status("overlap_set", st(1, 1, 0, 24'd64, 16'd0, 6'd0));
        chk_status("overlap_clear", st(1, 0, 0, 24'd64, 16'd0, 6'd0));
        push(40'h0, 8'd63, 16'd0);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        tick();
        pulse_cpl();
        pulse_cpl();
        chk_status("underflow_set", st(0, 0, 1, 24'd0, 16'd1, 6'd0));
        chk_status("underflow_clear", st(0, 0, 0, 24'd0, 16'd1, 6'd0));
        wait_drain("overlap");
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        base = accepted;
        for (int i = 0; i < 5; i++)
            push(40'(i * 64), 8'd63, 16'(i));
        cmd_ready = 1'b1;
        csr_write(40'h0, 24'd640);
        for (int i = 0; i < 50 && accepted - base < 5; i++) tick();
        cmd_ready = 1'b0;
        chk_status("mid_status", st(1, 0, 0, 24'd320, 16'd5, 6'd5));
        rst = 1'b1;
        tick();
        tests++;
        if (cmd_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_valid got=%b expected=0", cmd_valid);
        end
        rst = 1'b0;
        chk_status("mid_reset_status", 64'h0);
        cmd_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        cmd_ready = 1'b0;
        tests++;
        if (accepted - base != 5) begin
            fails++;
            $display("FAIL mid_no_cmds got=%0d expected=5", accepted - base);
        end
        pulse_cpl();
        chk_status("mid_late_cpl", st(0, 0, 1, 24'd0, 16'd0, 6'd0));
        wait_drain("reset_mid");
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        accepted    = 0;
        rst         = 1'b1;
        softreg_req = '0;
        cmd_ready   = 1'b0;
        cpl_valid   = 1'b0;
        test_reset();
        test_two_bursts();
        test_boundary();
        test_stall();
        test_backpressure();
        test_overlap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
